bnn_pred_collector: RTL and testbench

Sequential result collector at the output end of a BNN classifier such as `winewhite_bnn1_bnnparpnw`. It accepts a stream of (prediction, golden label) pairs over a valid/ready handshake and tallies per-class correct counts and a total correct count. After `TEST_CNT` pairs it streams the tallies out word by word. It lets an on-chip or FPGA harness score accuracy without a simulator printing predictions.

---
 rtl/bnn_collect_pkg.sv | 31 +++
 rtl/bnn_hit_counter_bank.sv | 44 ++++
 rtl/bnn_pred_collector.sv | 162 ++++++++++++++++
 tb/tb_bnn_pred_collector.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_collect_pkg.sv
// Shared types and width helpers for the BNN prediction collector.
// BNN_COLLECT_INVALID_EN adds the out-of-range prediction counter and its dump word.
package bnn_collect_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StDump,
    StDone
  } state_e;

`ifdef BNN_COLLECT_INVALID_EN
  localparam int unsigned ExtraWords = 2;
`else
  localparam int unsigned ExtraWords = 1;
`endif

  function automatic int unsigned pw_of(input int unsigned class_cnt);
    return (class_cnt > 1) ? $clog2(class_cnt) : 1;
  endfunction

  function automatic int unsigned cw_of(input int unsigned test_cnt);
    return $clog2(test_cnt + 1);
  endfunction

  // Per-class hits, then total, then the optional invalid count.
  function automatic int unsigned dump_words(input int unsigned class_cnt);
    return class_cnt + ExtraWords;
  endfunction

endpackage

// File: rtl/bnn_hit_counter_bank.sv
// Per-class hit counters with synchronous clear, indexed increment and indexed read.
// The read port doubles as the dump multiplexer; out-of-range reads return 0.
module bnn_hit_counter_bank
  import bnn_collect_pkg::*;
#(
  parameter int unsigned CLASS_CNT = 7,
  parameter int unsigned PW        = pw_of(CLASS_CNT),
  parameter int unsigned CW        = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  input  logic [PW-1:0] inc_idx,
  input  logic [3:0]    rd_idx,
  output logic [CW-1:0] rd_data
);

  logic [CW-1:0] hit_q [CLASS_CNT];

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      for (int k = 0; k < int'(CLASS_CNT); k++) begin
        hit_q[k] <= '0;
      end
    end else if (inc) begin
      for (int k = 0; k < int'(CLASS_CNT); k++) begin
        if (inc_idx == PW'(k)) begin
          hit_q[k] <= hit_q[k] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < int'(CLASS_CNT); k++) begin
      if (rd_idx == 4'(k)) begin
        rd_data = hit_q[k];
      end
    end
  end

endmodule

// File: rtl/bnn_pred_collector.sv
// Tallies (prediction, label) pairs for TEST_CNT samples, then streams per-class hits and total.
// Define BNN_COLLECT_INVALID_EN to also count predictions >= CLASS_CNT and dump that count last.
module bnn_pred_collector
  import bnn_collect_pkg::*;
#(
  parameter int unsigned CLASS_CNT = 7,
  parameter int unsigned TEST_CNT  = 1000,
  parameter int unsigned PW        = pw_of(CLASS_CNT),
  parameter int unsigned CW        = cw_of(TEST_CNT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_pred,
  input  logic [PW-1:0] in_label,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_data,
  output logic [3:0]    out_idx,
  output logic          done
);

  localparam int unsigned NWords  = dump_words(CLASS_CNT);
  localparam logic [3:0]  LastIdx = 4'(NWords - 1);

  state_e        state_q;
  logic [CW-1:0] n_q;
  logic [CW-1:0] total_q;
  logic [3:0]    idx_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic [CW-1:0] out_data_q;
  logic          done_q;
`ifdef BNN_COLLECT_INVALID_EN
  logic [CW-1:0] invalid_q;
`endif

  logic          xfer;
  logic          pred_ok;
  logic          last_in;
  logic          out_xfer;
  logic          restart;
  logic [3:0]    rd_idx;
  logic [CW-1:0] rd_data;
  logic [CW-1:0] next_word;

  assign xfer     = in_valid && in_ready_q;
  assign pred_ok  = (in_pred == in_label) && (32'(in_label) < CLASS_CNT);
  assign last_in  = xfer && (n_q == CW'(TEST_CNT - 1));
  assign out_xfer = out_valid_q && out_ready;
  assign restart  = start && ((state_q == StIdle) || (state_q == StDone));

  // Word 0 is loaded on the edge that accepts the final pair, so look one word ahead.
  assign rd_idx = last_in ? 4'd0 : idx_q + 4'd1;

  bnn_hit_counter_bank #(
    .CLASS_CNT(CLASS_CNT),
    .PW       (PW),
    .CW       (CW)
  ) u_hits (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (restart),
    .inc    (xfer && pred_ok),
    .inc_idx(in_label),
    .rd_idx (rd_idx),
    .rd_data(rd_data)
  );

  always_comb begin
    next_word = '0;
    if (32'(rd_idx) < CLASS_CNT) begin
      next_word = rd_data;
    end else if (32'(rd_idx) == CLASS_CNT) begin
      next_word = total_q;
    end
`ifdef BNN_COLLECT_INVALID_EN
    else begin
      next_word = invalid_q;
    end
`endif
    // The final pair's hit lands in the bank on the same edge; fold it into word 0.
    if (last_in && pred_ok && (in_label == '0)) begin
      next_word = next_word + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      n_q         <= '0;
      total_q     <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
`ifdef BNN_COLLECT_INVALID_EN
      invalid_q   <= '0;
`endif
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q    <= StCollect;
            n_q        <= '0;
            total_q    <= '0;
            idx_q      <= '0;
            out_data_q <= '0;
            in_ready_q <= 1'b1;
            done_q     <= 1'b0;
`ifdef BNN_COLLECT_INVALID_EN
            invalid_q  <= '0;
`endif
          end
        end
        StCollect: begin
          if (xfer) begin
            n_q <= n_q + CW'(1);
            if (pred_ok) begin
              total_q <= total_q + CW'(1);
            end
`ifdef BNN_COLLECT_INVALID_EN
            if (32'(in_pred) >= CLASS_CNT) begin
              invalid_q <= invalid_q + CW'(1);
            end
`endif
            if (last_in) begin
              state_q     <= StDump;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_data_q  <= next_word;
              idx_q       <= '0;
            end
          end
        end
        StDump: begin
          if (out_xfer) begin
            if (idx_q == LastIdx) begin
              state_q     <= StDone;
              out_valid_q <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              idx_q      <= idx_q + 4'd1;
              out_data_q <= next_word;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = idx_q;
  assign done      = done_q;

endmodule

// File: tb/tb_bnn_pred_collector.sv
// Scoreboard bench for bnn_pred_collector: expected dump words are queued per run and
// popped by an independent output monitor.
module tb_bnn_pred_collector;

  localparam int unsigned ClassCnt = 7;
  localparam int unsigned TestCnt  = 1000;
  localparam int unsigned Pw       = 3;
  localparam int unsigned Cw       = 10;

  typedef struct packed {
    logic [3:0]    idx;
    logic [Cw-1:0] data;
  } word_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [Pw-1:0] in_pred;
  logic [Pw-1:0] in_label;
  logic          out_valid;
  logic          out_ready;
  logic [Cw-1:0] out_data;
  logic [3:0]    out_idx;
  logic          done;

  word_t exp_q[$];
  int    tests = 0;
  int    fails = 0;
  bit    bp_mode = 1'b0;
  bit    took = 1'b0;
  int    stall = 0;

  bnn_pred_collector #(
    .CLASS_CNT(ClassCnt),
    .TEST_CNT (TestCnt)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_pred  (in_pred),
    .in_label (in_label),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_idx  (out_idx),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Output monitor: every presented word must match the scoreboard head, stalled or not.
  always @(negedge clk) begin
    took = 1'b0;
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_word: got idx %0d data %0d, expected no word", out_idx,
                 out_data);
      end else begin
        check("word_idx", int'(out_idx), int'(exp_q[0].idx));
        check("word_data", int'(out_data), int'(exp_q[0].data));
        if (out_ready) begin
          void'(exp_q.pop_front());
          took = 1'b1;
        end
      end
    end
  end

  // Consumer: in backpressure mode hold out_ready low for 5 cycles per word.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (!bp_mode) begin
        out_ready = 1'b1;
      end else if (took) begin
        out_ready = 1'b0;
        stall = 0;
      end else if (out_valid && !out_ready) begin
        stall++;
        if (stall >= 5) out_ready = 1'b1;
      end
    end
  end

  task automatic push_words(input int h[ClassCnt], input int total, input int inv);
    for (int k = 0; k < int'(ClassCnt); k++) exp_q.push_back({4'(k), Cw'(h[k])});
    exp_q.push_back({4'(ClassCnt), Cw'(total)});
`ifdef BNN_COLLECT_INVALID_EN
    exp_q.push_back({4'(ClassCnt + 1), Cw'(inv)});
`else
    if (inv < 0) $display("negative invalid count ignored");
`endif
  endtask

  task automatic pulse_start(input bit with_pair);
    start = 1'b1;
    if (with_pair) begin
      in_valid = 1'b1;
      in_pred  = '0;
      in_label = '0;
    end
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("in_ready_after_start", int'(in_ready), 1);
    check("done_after_start", int'(done), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int p, input int l, input bit gap);
    int w = 0;
    if (gap && $urandom_range(0, 1) == 1) begin
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_pred  = Pw'(p);
    in_label = Pw'(l);
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) check("in_ready_wait", int'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_dump_entry(input string name);
    @(negedge clk);
    check({name, "_dump_latency"}, int'(out_valid), 1);
    check({name, "_in_ready_drop"}, int'(in_ready), 0);
    check({name, "_first_idx"}, int'(out_idx), 0);
  endtask

  task automatic finish_run(input string name);
    int c = 0;
    while (done !== 1'b1 && c < 20000) begin
      @(negedge clk);
      c++;
    end
    check({name, "_done"}, int'(done), 1);
    check({name, "_words_left"}, exp_q.size(), 0);
    check({name, "_out_valid_low"}, int'(out_valid), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    check({name, "_in_ready"}, int'(in_ready), 0);
    check({name, "_out_valid"}, int'(out_valid), 0);
    check({name, "_out_data"}, int'(out_data), 0);
    check({name, "_out_idx"}, int'(out_idx), 0);
    check({name, "_done"}, int'(done), 0);
  endtask

  initial begin
    int h[ClassCnt];
    int p;
    int l;
    int c;

    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_pred  = '0;
    in_label = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst_n = 1'b1;
    in_valid = 1'b1;  // ignored without start
    repeat (3) check_idle("idle");
    @(posedge clk);
    #1;
    in_valid = 1'b0;

    // Run A: every pair correct; the pair offered together with start must be dropped.
    h = '{143, 143, 143, 143, 143, 143, 142};
    push_words(h, 1000, 0);
    pulse_start(1'b1);
    for (int i = 0; i < 1000; i++) send(i % 7, i % 7, 1'b0);
    check_dump_entry("all_correct");
    finish_run("all_correct");

    // Run B: only label 2 matches, random input gaps and output backpressure.
    bp_mode   = 1'b1;
    out_ready = 1'b0;
    h = '{0, 0, 300, 0, 0, 0, 0};
    push_words(h, 300, 0);
    pulse_start(1'b0);
    for (int i = 0; i < 1000; i++) begin
      if (i % 10 < 3) begin
        p = 2;
        l = 2;
      end else begin
        l = i % 7;
        if (l == 2) l = 3;
        p = (l + 1) % 7;
      end
      send(p, l, 1'b1);
    end
    check_dump_entry("backpressure");
    finish_run("backpressure");
    bp_mode = 1'b0;

    // Run C: restart from DONE, out-of-range pairs, start pulses ignored mid-run.
    h = '{0, 0, 0, 0, 0, 990, 0};
    push_words(h, 990, 10);
    pulse_start(1'b0);
    for (int i = 0; i < 1000; i++) begin
      if (i == 400 || i == 700) start = 1'b1;
      if (i < 10) send(7, 7, 1'b0);
      else send(5, 5, 1'b0);
      start = 1'b0;
    end
    check_dump_entry("invalid_restart");
    finish_run("invalid_restart");

    // Run D: reset while word 3 is stalled on the output.
    bp_mode   = 1'b1;
    out_ready = 1'b0;
    h = '{0, 1000, 0, 0, 0, 0, 0};
    push_words(h, 1000, 0);
    pulse_start(1'b0);
    for (int i = 0; i < 1000; i++) send(1, 1, 1'b0);
    c = 0;
    @(negedge clk);
    while (!(out_valid && out_idx == 4'd3) && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("reach_idx3", int'(out_idx), 3);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    bp_mode = 1'b0;
    rst_n   = 1'b1;
    check_idle("mid_dump_reset");
    check_idle("after_reset");

    // Run E: a fresh run after the abort counts from zero.
    h = '{0, 0, 0, 0, 500, 0, 0};
    push_words(h, 500, 0);
    pulse_start(1'b0);
    for (int i = 0; i < 1000; i++) begin
      if (i < 500) send(4, 4, 1'b0);
      else send(0, 1, 1'b0);
    end
    check_dump_entry("post_reset");
    finish_run("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
